seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Run controller for a programmable serial pattern detector. It holds the detection configuration: pattern, length and target match count. It sequences a detection run (idle, run, done) and accepts a serial bit stream over a valid/ready handshake. It flags each Mealy-style match in the cycle the completing bit is accepted and counts matches until the target is reached. It sits between the bit-stream source and the status/interrupt logic.

## Interface
- `MAX_LEN`, default 8: maximum pattern length in bits (≥2).
- `LEN_W`, default 4: width of the length field; must hold `MAX_LEN`.
- `CNT_W`, default 8: width of the match counter and target.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_pattern`  in  `MAX_LEN`  pattern; bit 0 is the most recent bit, bit `len-1` is the oldest.
- `cfg_len`  in  `LEN_W`  pattern length; legal values 1..`MAX_LEN`.
- `cfg_target`  in  `CNT_W`  number of matches that ends a run; 0 means run forever.
- `start`  in  1  begin a run (pulse).
- `abort`  in  1  terminate a run (pulse).
- `in_valid`  in  1  source presents `in_bit`.
- `in_bit`  in  1  serial data bit.
- `in_ready`  out  1  controller accepts bits; high only in RUN.
- `match`  out  1  combinational Mealy match for the bit being accepted this cycle.
- `match_count`  out  `CNT_W`  matches since last start; saturates at all-ones.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.

## Operation
- States:
  - IDLE: reset state.
  - RUN.
  - DONE.
- Internal registers:
  - `pat_q`, `len_q`, `tgt_q`.
  - `hist_q`: `MAX_LEN`-bit shift history.
  - `seen_q`: accepted-bit count, saturating at `MAX_LEN`.
- Configuration:
  - `cfg_we` in IDLE or DONE latches all three `cfg_*` fields. It is ignored in RUN.
  - Reset configuration: pattern `101`, `len_q`=3, `tgt_q`=0.
- IDLE/DONE + `start`, with `len_q` legal: go to RUN; clear `hist_q`, `seen_q` and `match_count`.
- `start` with `len_q`=0 or `len_q`>`MAX_LEN`: ignored; the state is unchanged.
- Bit acceptance:
  - A bit is accepted when `in_valid & in_ready`.
  - `hist_q` ← {`hist_q`[MAX_LEN-2:0], `in_bit`}.
  - `seen_q` increments, saturating.
- `match` = accept & (`seen_q`+1 ≥ `len_q`) & (low `len_q` bits of the new history == low `len_q` bits of `pat_q`).
- Default behaviour is overlapping detection: history is kept after a match.
- On `match`, `match_count` increments, saturating.
- If `tgt_q`≠0 and the post-increment count == `tgt_q`, go to DONE next cycle.
- RUN + `abort`: go to IDLE. `match_count` is held; history is discarded.
  - `abort` wins over a same-cycle match-to-DONE transition. The match still counts.
- DONE + `abort`: go to IDLE. IDLE + `abort`: no effect.
- `start` in RUN: ignored.
- `start` and `abort` together: `abort` wins.
- `cfg_we` and `start` in the same cycle: the new configuration is latched, and the run uses the new configuration.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=0, `busy`=0, `done`=0, `match`=0, `match_count`=0.
  - `hist_q`=0, `seen_q`=0.
- `start` sampled at edge N puts `busy`/`in_ready` high from cycle N+1.
- `match` has zero latency: it is asserted in the acceptance cycle. `match_count` updates at the following edge.
- The final match moves the block to DONE at the next edge:
  - `in_ready` drops in the cycle after the final accept.
  - No further bits are accepted.
- `match` is never asserted while `in_ready`=0.
- Reset asserted mid-run: immediate return to IDLE with reset values. The configuration returns to its reset configuration.
- Throughput: one bit per cycle while in RUN.

## Configuration
- `SEQ_DETECT_CTRL_NONOVERLAP_EN` undefined: overlapping detection as described above.
- `SEQ_DETECT_CTRL_NONOVERLAP_EN` defined: on every match, `seen_q` clears to 0 at the next edge. The next match therefore requires `len_q` fresh bits after the previous match.
- All other behaviour is identical in both builds.

## Test plan
- Reset config, `start`, stream `0011011001010100` at one bit/cycle (bit index 0..15), `tgt`=0, default build → `match` on bits 5, 11 and 13; `match_count`=3; stays in RUN.
- Same stream, build with `SEQ_DETECT_CTRL_NONOVERLAP_EN` → `match` on bits 5 and 11 only; `match_count`=2.
- `cfg_target`=2, same stream → DONE in the cycle after bit 11; `in_ready`=0 from then on; `done`=1; `match_count`=2; bits 12+ not accepted.
- `cfg_len`=0, `start` → stays IDLE, `busy`=0. Then `cfg_len`=8, pattern `0xA5`, `start`, feed `10100101` → one `match` on the 8th bit, none before it.
- Mid-run `abort` after 4 bits → IDLE next cycle, `match_count` held. A `cfg_we` issued in RUN has no effect on `pat_q`. Reset pulsed while `in_valid` is held high → all outputs 0 immediately.
- `in_valid` gaps: feed `1`,`0`,`1` with 3 idle cycles between bits → a single `match` on the third bit; history is unaffected by the idle cycles.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// Serial bit-stream channel between a bit source and seq_detect_ctrl.
// The master side presents bits; the slave side accepts them and reports Mealy matches.
interface seq_detect_ctrl_if;
  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic match;

  modport master (output in_valid, output in_bit, input in_ready, input match);
  modport slave  (input in_valid, input in_bit, output in_ready, output match);
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable serial pattern detector (IDLE/RUN/DONE).
// Define SEQ_DETECT_CTRL_NONOVERLAP_EN to restart the bit window after every match.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  seq_detect_ctrl_if.slave   stream,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [MAX_LEN-1:0] RST_PAT   = MAX_LEN'(5);
  localparam logic [LEN_W-1:0]   RST_LEN   = LEN_W'(3);
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   seen_q;

  logic               accept;
  logic               match_w;
  logic               len_hit;
  logic               pat_hit;
  logic               start_ok;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     seen_inc;
  logic [CNT_W-1:0]   count_inc;
  logic [LEN_W-1:0]   start_len;

  assign stream.in_ready = busy_q;
  assign busy            = busy_q;
  assign done            = done_q;

  // Match is judged on the history including the bit being accepted right now.
  assign accept    = stream.in_valid & busy_q;
  assign hist_next = {hist_q[MAX_LEN-2:0], stream.in_bit};
  assign len_mask  = ~({MAX_LEN{1'b1}} << len_q);
  assign seen_inc  = {1'b0, seen_q} + (LEN_W+1)'(1);
  assign len_hit   = seen_inc >= {1'b0, len_q};
  assign pat_hit   = ((hist_next ^ pat_q) & len_mask) == '0;
  assign match_w   = accept & len_hit & pat_hit;
  assign stream.match = match_w;

  assign count_inc = (match_count == CNT_MAX) ? match_count : match_count + CNT_W'(1);

  // A same-cycle config write decides whether the run may start.
  assign start_len = cfg_we ? cfg_len : len_q;
  assign start_ok  = start & ~abort & (start_len != '0) & (start_len <= MAX_LEN_L);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pat_q       <= RST_PAT;
      len_q       <= RST_LEN;
      tgt_q       <= '0;
      hist_q      <= '0;
      seen_q      <= '0;
      match_count <= '0;
    end else begin
      if (cfg_we && state_q != RUN) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        tgt_q <= cfg_target;
      end

      case (state_q)
        IDLE, DONE: begin
          if (abort) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end else if (start_ok) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            hist_q      <= '0;
            seen_q      <= '0;
            match_count <= '0;
          end
        end

        RUN: begin
          if (accept) begin
            hist_q <= hist_next;
`ifdef SEQ_DETECT_CTRL_NONOVERLAP_EN
            if (match_w) begin
              seen_q <= '0;
            end else if (seen_q < MAX_LEN_L) begin
              seen_q <= seen_q + LEN_W'(1);
            end
`else
            if (seen_q < MAX_LEN_L) begin
              seen_q <= seen_q + LEN_W'(1);
            end
`endif
          end

          if (match_w) begin
            match_count <= count_inc;
          end

          // Abort outranks reaching the target, but the final match is still counted.
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            hist_q  <= '0;
            seen_q  <= '0;
          end else if (match_w && tgt_q != '0 && count_inc == tgt_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Table-driven bench for seq_detect_ctrl with hand-computed expected values.
// Rows drive inputs just after a rising edge and check outputs before the next one.
module tb_seq_detect_ctrl;

  typedef struct {
    string      name;
    logic       start;
    logic       abort;
    logic       cfg_we;
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] tgt;
    logic       valid;
    logic       din;
    logic       exp_match;
    logic       exp_busy;
    logic       exp_done;
    logic [7:0] exp_count;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_target;
  logic       start;
  logic       abort;
  logic [7:0] match_count;
  logic       busy;
  logic       done;

  int passed;
  int total;
  vec_t vecs[$];

  seq_detect_ctrl_if sif ();

  seq_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .start       (start),
    .abort       (abort),
    .stream      (sif),
    .match_count (match_count),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input string n, input logic st, input logic ab, input logic we,
                         input logic [7:0] p, input logic [3:0] l, input logic [7:0] t,
                         input logic v, input logic d, input logic em, input logic eb,
                         input logic ed, input logic [7:0] ec);
    vec_t x;
    x.name = n; x.start = st; x.abort = ab; x.cfg_we = we;
    x.pat = p; x.len = l; x.tgt = t; x.valid = v; x.din = d;
    x.exp_match = em; x.exp_busy = eb; x.exp_done = ed; x.exp_count = ec;
    vecs.push_back(x);
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(posedge clk);
    #1;
    start       = v.start;
    abort       = v.abort;
    cfg_we      = v.cfg_we;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_target  = v.tgt;
    sif.in_valid = v.valid;
    sif.in_bit   = v.din;
  endtask

  task automatic check_output(input string n, input logic em, input logic eb,
                              input logic ed, input logic [7:0] ec);
    #3;
    total++;
    if (sif.match === em && busy === eb && done === ed && sif.in_ready === eb &&
        match_count === ec) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got match=%0b busy=%0b done=%0b ready=%0b count=%0d, expected match=%0b busy=%0b done=%0b ready=%0b count=%0d",
               n, sif.match, busy, done, sif.in_ready, match_count, em, eb, ed, eb, ec);
    end
  endtask

  task automatic run_vectors();
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i].name, vecs[i].exp_match, vecs[i].exp_busy,
                   vecs[i].exp_done, vecs[i].exp_count);
    end
    vecs.delete();
  endtask

  initial begin
    logic [15:0] stream_bits;
    logic [15:0] mask_a;
    logic [15:0] mask_b;
    logic [7:0]  pat_a5;
    logic [7:0]  cnt;

    // Bit i of stream_bits is stream bit i of 0011011001010100.
    stream_bits = 16'h2A6C;
`ifdef SEQ_DETECT_CTRL_NONOVERLAP_EN
    mask_a = 16'h0820;
`else
    mask_a = 16'h2820;
`endif
    mask_b = 16'h0820;
    pat_a5 = 8'hA5;
    passed = 0;
    total  = 0;

    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    sif.in_valid = 1'b1;
    sif.in_bit   = 1'b1;
    $display("[TB] reset state");
    check_output("reset_state", 0, 0, 0, 8'd0);
    #9;
    sif.in_valid = 1'b0;
    sif.in_bit   = 1'b0;
    reset_n      = 1'b1;

    // Reset configuration (101, len 3, target 0), free-running detection.
    cnt = 0;
    add_vec("a_start", 1,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,0, 8'd0);
    for (int i = 0; i < 16; i++) begin
      add_vec($sformatf("a_bit%0d", i), 0,0,0, 8'h00,4'd0,8'd0, 1,stream_bits[i],
              mask_a[i],1,0, cnt);
      cnt = cnt + {7'd0, mask_a[i]};
    end
    add_vec("a_hold",  0,0,0, 8'h00,4'd0,8'd0, 0,0, 0,1,0, cnt);
    add_vec("a_abort", 0,1,0, 8'h00,4'd0,8'd0, 0,0, 0,1,0, cnt);
    add_vec("a_idle",  0,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,0, cnt);

    // Target of 2 written in the same cycle as start.
    add_vec("b_cfg_start", 1,0,1, 8'h05,4'd3,8'd2, 0,0, 0,0,0, cnt);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      add_vec($sformatf("b_bit%0d", i), 0,0,0, 8'h00,4'd0,8'd0, 1,stream_bits[i],
              mask_b[i],1,0, cnt);
      cnt = cnt + {7'd0, mask_b[i]};
    end
    for (int i = 12; i < 16; i++) begin
      add_vec($sformatf("b_done_bit%0d", i), 0,0,0, 8'h00,4'd0,8'd0, 1,stream_bits[i],
              0,0,1, 8'd2);
    end
    add_vec("b_cfg_len0",   0,0,1, 8'h05,4'd0,8'd0, 0,0, 0,0,1, 8'd2);
    add_vec("b_start_bad",  1,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,1, 8'd2);
    add_vec("b_still_done", 0,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,1, 8'd2);
    add_vec("b_abort",      0,1,0, 8'h00,4'd0,8'd0, 0,0, 0,0,1, 8'd2);
    add_vec("b_idle",       0,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,0, 8'd2);
    add_vec("b_start_len0", 1,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,0, 8'd2);
    add_vec("b_not_run",    0,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,0, 8'd2);

    // Full-length pattern 0xA5, then a config write during RUN that must be ignored.
    add_vec("c_cfg",   0,0,1, 8'hA5,4'd8,8'd0, 0,0, 0,0,0, 8'd2);
    add_vec("c_start", 1,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,0, 8'd2);
    for (int k = 0; k < 8; k++) begin
      add_vec($sformatf("c_a5_bit%0d", k), 0,0,0, 8'h00,4'd0,8'd0, 1,pat_a5[7-k],
              (k == 7),1,0, 8'd0);
    end
    add_vec("c_cfg_in_run", 0,0,1, 8'h01,4'd1,8'd1, 0,0, 0,1,0, 8'd1);
    for (int k = 0; k < 8; k++) begin
      add_vec($sformatf("c_a5_again%0d", k), 0,0,0, 8'h00,4'd0,8'd0, 1,pat_a5[7-k],
              (k == 7),1,0, 8'd1);
    end
    for (int k = 0; k < 4; k++) begin
      add_vec($sformatf("c_ones%0d", k), 0,0,0, 8'h00,4'd0,8'd0, 1,1, 0,1,0, 8'd2);
    end
    add_vec("c_abort", 0,1,0, 8'h00,4'd0,8'd0, 0,0, 0,1,0, 8'd2);
    add_vec("c_idle",  0,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,0, 8'd2);
    add_vec("r_start", 1,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,0, 8'd2);
    $display("[TB] directed vector table");
    run_vectors();

    // Asynchronous reset while a bit is being offered.
    $display("[TB] reset mid-run");
    @(posedge clk);
    #1;
    start = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_bit   = 1'b1;
    check_output("r_running", 0, 1, 0, 8'd0);
    reset_n = 1'b0;
    check_output("r_reset_async", 0, 0, 0, 8'd0);
    @(posedge clk);
    #1;
    check_output("r_reset_held", 0, 0, 0, 8'd0);
    @(negedge clk);
    sif.in_valid = 1'b0;
    reset_n      = 1'b1;

    // Restored 101 configuration with idle gaps between accepted bits.
    add_vec("d_start", 1,0,0, 8'h00,4'd0,8'd0, 0,0, 0,0,0, 8'd0);
    add_vec("d_b0",    0,0,0, 8'h00,4'd0,8'd0, 1,1, 0,1,0, 8'd0);
    for (int g = 0; g < 3; g++)
      add_vec($sformatf("d_gap_a%0d", g), 0,0,0, 8'h00,4'd0,8'd0, 0,1, 0,1,0, 8'd0);
    add_vec("d_b1",    0,0,0, 8'h00,4'd0,8'd0, 1,0, 0,1,0, 8'd0);
    for (int g = 0; g < 3; g++)
      add_vec($sformatf("d_gap_b%0d", g), 0,0,0, 8'h00,4'd0,8'd0, 0,0, 0,1,0, 8'd0);
    add_vec("d_b2",    0,0,0, 8'h00,4'd0,8'd0, 1,1, 1,1,0, 8'd0);
    add_vec("d_hold",  0,0,0, 8'h00,4'd0,8'd0, 0,0, 0,1,0, 8'd1);
    $display("[TB] idle gaps");
    run_vectors();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
